// File: rtl/ccm_pkg.sv
// Shared types for the cryptographic module's AHB slave front end.
// Contents:
//   htrans_t     - AHB HTRANS encoding (IDLE, BUSY, NONSEQ, SEQ)
//   slv_state_e  - write-slave FSM states
//   is_active()  - true for NONSEQ/SEQ, the only transfers that open an address phase
package ccm_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'd0,
    HtransBusy   = 2'd1,
    HtransNonseq = 2'd2,
    HtransSeq    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StData = 3'd2,
    StLast = 3'd3,
    StErr1 = 3'd4,
    StErr2 = 3'd5
  } slv_state_e;

  function automatic logic is_active(input htrans_t trans);
    return (trans == HtransNonseq) || (trans == HtransSeq);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO with registered storage and no fall-through:
// a pushed word becomes visible at the head one cycle after the push.
// Ports:
//   clk, rst    - clock and synchronous active-high reset (pointers only)
//   push, wdata - write strobe and data; ignored when full unless popping too
//   pop, rdata  - read strobe and head-of-queue data; ignored when empty
//   full, empty - occupancy flags
//   count       - occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 129,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    count   = wptr_q - rptr_q;
    full    = (count == (AW+1)'(DEPTH));
    empty   = (wptr_q == rptr_q);
    do_pop  = pop & ~empty;
    // Full is fine when the head leaves in the same cycle.
    do_push = push & (~full | do_pop);
    rdata   = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage is not reset; contents behind the pointers are don't-care.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ahb_slave_burst_buffer.sv
// AHB-Lite write slave that receives a destination address word followed by a
// stream of data blocks, buffers the blocks, and hands them to the cipher core.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   HSELx .. HWDATA   - AHB-Lite slave inputs (HREADY is the bus-wide ready)
//   data_done         - current data phase carries the final block
//   HREADYOUT, HRESP  - slave response; wait states on a full FIFO, 2-cycle ERROR on reads
//   blk_data/valid    - FIFO head towards the core; popped on blk_valid & blk_ready
//   blk_ready         - core accepts the head
//   dest_addr/valid   - destination address captured from the first data word
//   count             - FIFO occupancy
//   stream_done       - one-cycle pulse after the final block has been popped
//   overflow_err      - sticky: data arrived after data_done but before drain
module ahb_slave_burst_buffer
  import ccm_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       HSELx,
  input  logic                       HWRITE,
  input  logic [1:0]                 HTRANS,
  input  logic                       HREADY,
  input  logic [DATA_W-1:0]          HWDATA,
  input  logic                       data_done,
  output logic                       HREADYOUT,
  output logic                       HRESP,
  output logic [DATA_W-1:0]          blk_data,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic [ADDR_W-1:0]          dest_addr,
  output logic                       dest_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       stream_done,
  output logic                       overflow_err
);

  slv_state_e          state_q, state_d, ret_q, ret_d, cur, nxt;
  logic                pending_q, pending_d;
  logic                dest_valid_q, dest_valid_d;
  logic [ADDR_W-1:0]   dest_addr_q, dest_addr_d;
  logic                stream_done_q, overflow_q, hresp_q;

  logic                accept, accept_wr, accept_rd;
  logic                pop, push, stall, hready_out, dphase, drain, misuse;
  logic                fifo_full, fifo_empty, head_last;
  logic [DATA_W:0]     fifo_rdata;

  sync_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata({data_done, HWDATA}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(count)
  );

  always_comb begin
    accept    = HSELx & HREADY & is_active(htrans_t'(HTRANS));
    accept_wr = accept & HWRITE;
    accept_rd = accept & ~HWRITE;

    // While answering a read with ERROR, the stream carries on in the state it
    // will return to, so a drain that completes during ERR1/ERR2 is not lost.
    cur = ((state_q == StErr1) || (state_q == StErr2)) ? ret_q : state_q;

    pop        = ~fifo_empty & blk_ready;
    head_last  = fifo_rdata[DATA_W];
    stall      = pending_q & (cur == StData) & fifo_full & ~pop;
    hready_out = (state_q != StErr1) & ~stall;
    dphase     = pending_q & hready_out;
    push       = dphase & (cur == StData);
    drain      = pop & head_last & (cur == StLast);
    // A data phase landing in LAST, or in IDLE right after a drain, belongs to
    // a write issued after data_done: it is dropped.
    misuse     = dphase & ((cur == StLast) || (cur == StIdle));
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      StIdle: if (accept_wr) nxt = dest_valid_q ? StData : StAddr;
      StAddr: if (dphase)    nxt = accept_wr ? StData : StIdle;
      StData: if (push & data_done) nxt = StLast;
      StLast: if (drain)     nxt = StIdle;
      default:               nxt = StIdle;
    endcase

    state_d = nxt;
    ret_d   = ret_q;
    if (accept_rd) begin
      state_d = StErr1;
      ret_d   = nxt;
    end else if (state_q == StErr1) begin
      state_d = StErr2;
      ret_d   = nxt;
    end

    pending_d = pending_q;
    if (accept_wr)   pending_d = 1'b1;
    else if (dphase) pending_d = 1'b0;

    dest_addr_d  = dest_addr_q;
    dest_valid_d = dest_valid_q;
    if (dphase && (cur == StAddr)) begin
      dest_addr_d  = HWDATA[ADDR_W-1:0];
      dest_valid_d = 1'b1;
    end
    if (drain) dest_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ret_q         <= StIdle;
      pending_q     <= 1'b0;
      dest_addr_q   <= '0;
      dest_valid_q  <= 1'b0;
      stream_done_q <= 1'b0;
      overflow_q    <= 1'b0;
      hresp_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      pending_q     <= pending_d;
      dest_addr_q   <= dest_addr_d;
      dest_valid_q  <= dest_valid_d;
      stream_done_q <= drain;
      overflow_q    <= overflow_q | misuse;
      hresp_q       <= (state_d == StErr1) || (state_d == StErr2);
    end
  end

  assign HREADYOUT    = hready_out;
  assign HRESP        = hresp_q;
  assign blk_data     = fifo_rdata[DATA_W-1:0];
  assign blk_valid    = ~fifo_empty;
  assign dest_addr    = dest_addr_q;
  assign dest_valid   = dest_valid_q;
  assign stream_done  = stream_done_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_ahb_slave_burst_buffer.sv
// Directed bench for ahb_slave_burst_buffer (DATA_W=32, DEPTH=4).
module tb_ahb_slave_burst_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite, hready, data_done, blk_ready;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hreadyout, hresp, blk_valid, dest_valid, stream_done, overflow_err;
  logic [31:0] blk_data, dest_addr;
  logic [2:0]  count;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] popq[$];
  logic [31:0] w [8];

  always #5 clk = ~clk;

  // Single-slave bus: the global ready is this slave's ready.
  assign hready = hreadyout;

  ahb_slave_burst_buffer #(
    .DATA_W(32),
    .DEPTH (4),
    .ADDR_W(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .HSELx       (hsel),
    .HWRITE      (hwrite),
    .HTRANS      (htrans),
    .HREADY      (hready),
    .HWDATA      (hwdata),
    .data_done   (data_done),
    .HREADYOUT   (hreadyout),
    .HRESP       (hresp),
    .blk_data    (blk_data),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .dest_addr   (dest_addr),
    .dest_valid  (dest_valid),
    .count       (count),
    .stream_done (stream_done),
    .overflow_err(overflow_err)
  );

  always @(posedge clk) begin
    if (!rst && blk_valid && blk_ready) popq.push_back(blk_data);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Pipelined write of w[0..n-1]; holds a data phase while HREADYOUT is low.
  task automatic ahb_write_burst(input int n, input bit done_last, input int ready_after,
                                 output int stalls, output int first_stall,
                                 output int cnt_first, output int cnt_last, output bit timeout);
    int k = 0;
    int budget = 100;
    stalls = 0; first_stall = -1; cnt_first = -1; cnt_last = -1;
    while (k <= n && budget > 0) begin
      @(negedge clk);
      hsel      = 1'b1;
      hwrite    = 1'b1;
      htrans    = (k < n) ? ((k == 0) ? 2'b10 : 2'b11) : 2'b00;
      hwdata    = (k > 0) ? w[k-1] : 32'h0;
      data_done = done_last && (k == n) && (k > 0);
      if (ready_after >= 0 && stalls == ready_after) blk_ready = 1'b1;
      #1;
      if (hreadyout) k++;
      else begin
        if (stalls == 0) begin
          first_stall = k - 1;
          cnt_first   = int'(count);
        end
        cnt_last = int'(count);
        stalls++;
      end
      budget--;
    end
    timeout = (k <= n);
    @(negedge clk);
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0; data_done = 1'b0;
  endtask

  task automatic wait_stream_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stream_done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; hsel = 1'b0; hwrite = 1'b0; htrans = 2'b00; hwdata = 32'h0;
    data_done = 1'b0; blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL rst_hreadyout got=%b exp=1", hreadyout); end
    n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL rst_hresp got=%b exp=0", hresp); end
    n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL rst_blk_valid got=%b exp=0", blk_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", count); end
    n_checks++; if (dest_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dest_valid got=%b exp=0", dest_valid); end
    n_checks++; if (dest_addr !== 32'h0) begin n_fail++; $display("FAIL rst_dest_addr got=%h exp=0", dest_addr); end
    n_checks++; if (stream_done !== 1'b0) begin n_fail++; $display("FAIL rst_stream_done got=%b exp=0", stream_done); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got=%b exp=0", overflow_err); end
    // Unselected NONSEQ writes must be ignored.
    hsel = 1'b0; hwrite = 1'b1; htrans = 2'b10; hwdata = 32'h1234;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (dest_valid !== 1'b0) begin n_fail++; $display("FAIL unsel_dest_valid got=%b exp=0", dest_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL unsel_count got=%0d exp=0", count); end
    n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL unsel_hreadyout got=%b exp=1", hreadyout); end
    htrans = 2'b00; hwdata = 32'h0;
  endtask

  task automatic test_stream3();
    int st, fs, cf, cl;
    bit to;
    logic [31:0] got;
    popq.delete();
    blk_ready = 1'b1;
    w[0] = 32'h0000_1111; w[1] = 32'hA0A0_0001; w[2] = 32'hB0B0_0002; w[3] = 32'hC0C0_0003;
    ahb_write_burst(4, 1'b1, -1, st, fs, cf, cl, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL s3_timeout got=%b exp=0", to); end
    n_checks++; if (st != 0) begin n_fail++; $display("FAIL s3_stalls got=%0d exp=0", st); end
    n_checks++; if (dest_addr !== 32'h1111) begin n_fail++; $display("FAIL s3_dest_addr got=%h exp=1111", dest_addr); end
    n_checks++; if (dest_valid !== 1'b1) begin n_fail++; $display("FAIL s3_dest_valid got=%b exp=1", dest_valid); end
    n_checks++; if (blk_data !== w[3]) begin n_fail++; $display("FAIL s3_head got=%h exp=%h", blk_data, w[3]); end
    n_checks++; if (stream_done !== 1'b0) begin n_fail++; $display("FAIL s3_done_early got=%b exp=0", stream_done); end
    @(negedge clk);
    n_checks++; if (stream_done !== 1'b1) begin n_fail++; $display("FAIL s3_done_pulse got=%b exp=1", stream_done); end
    n_checks++; if (dest_valid !== 1'b0) begin n_fail++; $display("FAIL s3_dest_clear got=%b exp=0", dest_valid); end
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL s3_count got=%0d exp=0", count); end
    @(negedge clk);
    n_checks++; if (stream_done !== 1'b0) begin n_fail++; $display("FAIL s3_done_width got=%b exp=0", stream_done); end
    n_checks++; if (popq.size() != 3) begin n_fail++; $display("FAIL s3_npop got=%0d exp=3", popq.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < popq.size()) ? popq[i] : 32'hxxxx_xxxx;
      n_checks++; if (got !== w[i+1]) begin n_fail++; $display("FAIL s3_order[%0d] got=%h exp=%h", i, got, w[i+1]); end
    end
  endtask

  task automatic test_backpressure();
    int st, fs, cf, cl, cyc;
    bit to;
    logic [31:0] got;
    popq.delete();
    blk_ready = 1'b0;
    w[0] = 32'h0000_2222;
    for (int i = 1; i <= 6; i++) w[i] = 32'hD000_0000 + i;
    ahb_write_burst(7, 1'b1, 3, st, fs, cf, cl, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout got=%b exp=0", to); end
    n_checks++; if (fs != 5) begin n_fail++; $display("FAIL bp_first_stall got=%0d exp=5", fs); end
    n_checks++; if (st != 3) begin n_fail++; $display("FAIL bp_stalls got=%0d exp=3", st); end
    n_checks++; if (cf != 4) begin n_fail++; $display("FAIL bp_count_first got=%0d exp=4", cf); end
    n_checks++; if (cl != 4) begin n_fail++; $display("FAIL bp_count_held got=%0d exp=4", cl); end
    wait_stream_done(cyc);
    n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL bp_stream_done got=timeout exp=pulse"); end
    n_checks++; if (dest_addr !== 32'h2222) begin n_fail++; $display("FAIL bp_dest_addr got=%h exp=2222", dest_addr); end
    n_checks++; if (popq.size() != 6) begin n_fail++; $display("FAIL bp_npop got=%0d exp=6", popq.size()); end
    for (int i = 0; i < 6; i++) begin
      got = (i < popq.size()) ? popq[i] : 32'hxxxx_xxxx;
      n_checks++; if (got !== w[i+1]) begin n_fail++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got, w[i+1]); end
    end
  endtask

  task automatic test_full_pop();
    int st, fs, cf, cl, cyc;
    bit to;
    logic [31:0] got;
    popq.delete();
    blk_ready = 1'b0;
    w[0] = 32'h0000_3333;
    for (int i = 1; i <= 5; i++) w[i] = 32'hE000_0000 + i;
    ahb_write_burst(5, 1'b0, -1, st, fs, cf, cl, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL fp_timeout got=%b exp=0", to); end
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fp_filled got=%0d exp=4", count); end
    @(negedge clk);
    hsel = 1'b1; hwrite = 1'b1; htrans = 2'b10;
    #1;
    n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL fp_addr_ready got=%b exp=1", hreadyout); end
    @(negedge clk);
    htrans = 2'b00; hwdata = w[5]; data_done = 1'b1; blk_ready = 1'b1;
    #1;
    n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL fp_no_wait got=%b exp=1", hreadyout); end
    @(negedge clk);
    hsel = 1'b0; data_done = 1'b0; hwdata = 32'h0; blk_ready = 1'b0;
    #1;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fp_count got=%0d exp=4", count); end
    n_checks++; if (blk_data !== w[2]) begin n_fail++; $display("FAIL fp_head got=%h exp=%h", blk_data, w[2]); end
    blk_ready = 1'b1;
    wait_stream_done(cyc);
    n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL fp_stream_done got=timeout exp=pulse"); end
    n_checks++; if (popq.size() != 5) begin n_fail++; $display("FAIL fp_npop got=%0d exp=5", popq.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < popq.size()) ? popq[i] : 32'hxxxx_xxxx;
      n_checks++; if (got !== w[i+1]) begin n_fail++; $display("FAIL fp_order[%0d] got=%h exp=%h", i, got, w[i+1]); end
    end
  endtask

  task automatic test_read_error();
    int st, fs, cf, cl, cyc;
    bit to;
    logic [31:0] got;
    popq.delete();
    blk_ready = 1'b0;
    w[0] = 32'h0000_4444; w[1] = 32'hF000_0001;
    ahb_write_burst(2, 1'b0, -1, st, fs, cf, cl, to);
    @(negedge clk);
    hsel = 1'b1; hwrite = 1'b0; htrans = 2'b10;
    @(negedge clk);
    hsel = 1'b0; hwrite = 1'b1; htrans = 2'b00;
    #1;
    n_checks++; if (hresp !== 1'b1) begin n_fail++; $display("FAIL re_err1_hresp got=%b exp=1", hresp); end
    n_checks++; if (hreadyout !== 1'b0) begin n_fail++; $display("FAIL re_err1_ready got=%b exp=0", hreadyout); end
    @(negedge clk);
    #1;
    n_checks++; if (hresp !== 1'b1) begin n_fail++; $display("FAIL re_err2_hresp got=%b exp=1", hresp); end
    n_checks++; if (hreadyout !== 1'b1) begin n_fail++; $display("FAIL re_err2_ready got=%b exp=1", hreadyout); end
    @(negedge clk);
    #1;
    n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL re_after_hresp got=%b exp=0", hresp); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL re_count got=%0d exp=1", count); end
    w[0] = 32'hF000_0002;
    ahb_write_burst(1, 1'b1, -1, st, fs, cf, cl, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL re_resume_timeout got=%b exp=0", to); end
    blk_ready = 1'b1;
    wait_stream_done(cyc);
    n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL re_stream_done got=timeout exp=pulse"); end
    n_checks++; if (dest_addr !== 32'h4444) begin n_fail++; $display("FAIL re_dest_addr got=%h exp=4444", dest_addr); end
    n_checks++; if (popq.size() != 2) begin n_fail++; $display("FAIL re_npop got=%0d exp=2", popq.size()); end
    got = (popq.size() > 1) ? popq[1] : 32'hxxxx_xxxx;
    n_checks++; if (got !== 32'hF000_0002) begin n_fail++; $display("FAIL re_second got=%h exp=f0000002", got); end
  endtask

  task automatic test_misuse_abort();
    int st, fs, cf, cl, cyc;
    bit to, seen;
    logic [31:0] got;
    popq.delete();
    blk_ready = 1'b0;
    w[0] = 32'h0000_5555; w[1] = 32'h6000_0001;
    ahb_write_burst(2, 1'b1, -1, st, fs, cf, cl, to);
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL mu_pre_overflow got=%b exp=0", overflow_err); end
    w[0] = 32'h6000_0002;
    ahb_write_burst(1, 1'b0, -1, st, fs, cf, cl, to);
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL mu_overflow got=%b exp=1", overflow_err); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL mu_count got=%0d exp=1", count); end
    blk_ready = 1'b1;
    wait_stream_done(cyc);
    n_checks++; if (cyc < 0) begin n_fail++; $display("FAIL mu_stream_done got=timeout exp=pulse"); end
    n_checks++; if (popq.size() != 1) begin n_fail++; $display("FAIL mu_npop got=%0d exp=1", popq.size()); end
    got = (popq.size() > 0) ? popq[0] : 32'hxxxx_xxxx;
    n_checks++; if (got !== 32'h6000_0001) begin n_fail++; $display("FAIL mu_kept got=%h exp=60000001", got); end
    n_checks++; if (overflow_err !== 1'b1) begin n_fail++; $display("FAIL mu_sticky got=%b exp=1", overflow_err); end
    // Abort a partly buffered stream with reset.
    popq.delete();
    blk_ready = 1'b0;
    w[0] = 32'h0000_6666; w[1] = 32'h7000_0001; w[2] = 32'h7000_0002;
    ahb_write_burst(3, 1'b0, -1, st, fs, cf, cl, to);
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL ab_pre_count got=%0d exp=2", count); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL ab_count got=%0d exp=0", count); end
    n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL ab_blk_valid got=%b exp=0", blk_valid); end
    n_checks++; if (dest_valid !== 1'b0) begin n_fail++; $display("FAIL ab_dest_valid got=%b exp=0", dest_valid); end
    n_checks++; if (overflow_err !== 1'b0) begin n_fail++; $display("FAIL ab_overflow got=%b exp=0", overflow_err); end
    blk_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (stream_done) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL ab_no_done got=%b exp=0", seen); end
    n_checks++; if (popq.size() != 0) begin n_fail++; $display("FAIL ab_npop got=%0d exp=0", popq.size()); end
  endtask

  initial begin
    test_reset();
    test_stream3();
    test_backpressure();
    test_full_pop();
    test_read_error();
    test_misuse_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
